// File: rtl/i2c_pkg.sv
// Shared types for the I2C target and its bus-side helpers.
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic ACK          = 1'b0;
  localparam logic NACK         = 1'b1;
endpackage

// File: rtl/i2c_slave_target_if.sv
// User-side byte handshake of the I2C target (receive and transmit paths).
interface i2c_slave_target_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       busy;

  modport slave  (output rx_data, rx_valid, tx_ack, busy, input rx_ready, tx_data);
  modport master (input rx_data, rx_valid, tx_ack, busy, output rx_ready, tx_data);
endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronisers plus one history flop; emits single-cycle bus strobes.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_h, sda_h, scl_s;

  // Idle-high reset so a released bus produces no spurious edges.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_h <= 1'b1;
      sda_h <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
      scl_h <= scl_s;
      sda_h <= sda_s;
    end
  end

  assign scl_s     = scl_q[SYNC_STAGES-1];
  assign sda_s     = sda_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
endmodule

// File: rtl/i2c_slave_target.sv
// I2C target: address match, ACK/NACK, byte write into and byte read from the user side.
module i2c_slave_target import i2c_pkg::*; #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b1001100,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk100mhz,
  input  logic               res,
  input  logic               scl,
  inout  wire                sda,
  i2c_slave_target_if.slave  usr
);
  logic sda_s, scl_rise, scl_fall, start_det, stop_det;
  i2c_state_e state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, shift_in;
  logic       rw, ack_ok, ack_slot, sda_oe;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .gclk(clk100mhz), .grst_n(res), .scl(scl), .sda(sda),
    .sda_s(sda_s), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det)
  );

  assign shift_in = {shreg[6:0], sda_s};
  assign sda      = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk100mhz or negedge res) begin
    if (!res) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      rw           <= 1'b0;
      ack_ok       <= 1'b0;
      ack_slot     <= 1'b0;
      sda_oe       <= 1'b0;
      usr.rx_data  <= '0;
      usr.rx_valid <= 1'b0;
      usr.tx_ack   <= 1'b0;
      usr.busy     <= 1'b0;
    end else begin
      usr.rx_valid <= 1'b0;
      usr.tx_ack   <= 1'b0;
      if (stop_det) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        usr.busy <= 1'b0;
      end else if (start_det) begin
        state    <= ADDR;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        usr.busy <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (shift_in[7:1] == SLAVE_ADDR) begin
                usr.busy <= 1'b1;
                rw       <= (shift_in[0] == I2C_RW_READ);
                ack_slot <= 1'b0;
                state    <= ADDR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          // First fall opens the ACK slot, second fall closes it.
          ADDR_ACK: if (scl_fall) begin
            if (!ack_slot) begin
              sda_oe   <= 1'b1;
              ack_slot <= 1'b1;
            end else if (rw == I2C_RW_WRITE) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= WR_DATA;
            end else begin
              shreg      <= usr.tx_data;
              usr.tx_ack <= 1'b1;
              sda_oe     <= ~usr.tx_data[7];
              bit_cnt    <= 4'd1;
              state      <= RD_DATA;
            end
          end
          WR_DATA: if (scl_rise) begin
            shreg   <= shift_in;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ack_ok   <= usr.rx_ready;
              ack_slot <= 1'b0;
              state    <= WR_ACK;
              if (usr.rx_ready) begin
                usr.rx_data  <= shift_in;
                usr.rx_valid <= 1'b1;
              end
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!ack_slot) begin
              sda_oe   <= ack_ok;
              ack_slot <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= ack_ok ? WR_DATA : WAIT_STOP;
            end
          end
          // bit_cnt counts bits already presented; the MSB went out on entry.
          RD_DATA: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
              state  <= RD_ACK;
            end else begin
              sda_oe  <= ~shreg[6];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_s == NACK) begin
              state <= WAIT_STOP;
            end else if (scl_fall) begin
              shreg      <= usr.tx_data;
              usr.tx_ack <= 1'b1;
              sda_oe     <= ~usr.tx_data[7];
              bit_cnt    <= 4'd1;
              state      <= RD_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_target.sv
// Bit-banged I2C master driving the target, checked against a byte-level model.
module tb_i2c_slave_target;
  import i2c_pkg::*;

  localparam logic [6:0] SADDR = 7'b1001100;
  localparam int Q = 8;

  logic clk100mhz = 1'b0;
  logic res = 1'b1;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_target_if usr_if ();

  i2c_slave_target #(.SLAVE_ADDR(SADDR), .SYNC_STAGES(2)) dut (
    .clk100mhz(clk100mhz), .res(res), .scl(scl), .sda(sda), .usr(usr_if.slave)
  );

  always #5 clk100mhz = ~clk100mhz;

  int total = 0, bad = 0;
  int rxv_cyc = 0, txa_cyc = 0, tgt_low = 0;
  logic [7:0] exp_rx = 8'h00;

  // Pulse widths and target-driven low cycles, sampled mid-low-phase of clk.
  always begin
    @(negedge clk100mhz);
    #1;
    if (usr_if.rx_valid) rxv_cyc++;
    if (usr_if.tx_ack) txa_cyc++;
    if (!m_low && sda === 1'b0) tgt_low++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk100mhz);
  endtask

  task automatic bus_start;
    m_low = 1'b0; wait_q(Q);
    scl = 1'b1;   wait_q(Q);
    m_low = 1'b1; wait_q(Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop;
    m_low = 1'b1; wait_q(Q);
    scl = 1'b1;   wait_q(Q);
    m_low = 1'b0; wait_q(2*Q);
  endtask

  task automatic send_bit(input logic b, output logic seen);
    wait_q(Q); m_low = ~b;
    wait_q(Q); scl = 1'b1;
    wait_q(Q); seen = sda;
    wait_q(Q); scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0;
    wait_q(2*Q); scl = 1'b1;
    wait_q(Q);   b = sda;
    wait_q(Q);   scl = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    recv_bit(ack);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic mack, input logic [7:0] nxt,
                         output logic seen);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    usr_if.tx_data = nxt;
    send_bit(~mack, seen);
  endtask

  // One full transaction; expectations come from the I2C byte protocol rules.
  task automatic txn(input string nm, input logic [7:0] abyte, input int n,
                     input logic [3:0][7:0] dat, input logic [3:0] rdy);
    logic a, s, hit;
    logic [7:0] d;
    int rv0, ta0, tl0, exp_rv, exp_ta;
    rv0 = rxv_cyc; ta0 = txa_cyc; tl0 = tgt_low; exp_rv = 0; exp_ta = 0;
    hit = (abyte[7:1] == SADDR);
    usr_if.tx_data = dat[0];
    bus_start;
    wr_byte(abyte, a);
    chk({nm, "_aack"}, 32'(a), 32'(hit ? ACK : NACK));
    chk({nm, "_busy"}, 32'(usr_if.busy), 32'(hit));
    if (hit && abyte[0] == I2C_RW_WRITE) begin
      for (int i = 0; i < n; i++) begin
        usr_if.rx_ready = rdy[i];
        wr_byte(dat[i], a);
        chk({nm, "_dack"}, 32'(a), 32'(rdy[i] ? ACK : NACK));
        if (!rdy[i]) break;
        exp_rx = dat[i];
        exp_rv++;
      end
    end else if (hit) begin
      exp_ta = n;
      for (int i = 0; i < n; i++) begin
        rd_byte(d, i < n-1, dat[i+1], s);
        chk({nm, "_rd"}, 32'(d), 32'(dat[i]));
        if (i == n-1) chk({nm, "_rel"}, 32'(s), 32'(1));
      end
    end else begin
      wr_byte(dat[0], a);
      chk({nm, "_ignore"}, 32'(a), 32'(NACK));
    end
    bus_stop;
    chk({nm, "_idle"}, 32'(usr_if.busy), 32'(0));
    chk({nm, "_rx"}, 32'(usr_if.rx_data), 32'(exp_rx));
    chk({nm, "_rxv"}, rxv_cyc - rv0, exp_rv);
    chk({nm, "_txa"}, txa_cyc - ta0, exp_ta);
    if (!hit) chk({nm, "_quiet"}, tgt_low - tl0, 0);
    usr_if.rx_ready = 1'b1;
  endtask

  initial begin
    logic a, s;
    logic [7:0] d;
    logic [6:0] a7;
    logic [3:0][7:0] dat;
    logic [3:0] rdy;
    int rv0;

    usr_if.rx_ready = 1'b1;
    usr_if.tx_data  = 8'h00;
    #1 res = 1'b0;
    wait_q(4);
    chk("rst_rx_data", 32'(usr_if.rx_data), 32'(0));
    chk("rst_rx_valid", 32'(usr_if.rx_valid), 32'(0));
    chk("rst_tx_ack", 32'(usr_if.tx_ack), 32'(0));
    chk("rst_busy", 32'(usr_if.busy), 32'(0));
    chk("rst_sda", 32'(sda), 32'(1));
    res = 1'b1;
    wait_q(4);

    txn("wr",  8'h98, 1, {8'h00, 8'h00, 8'h00, 8'h55}, 4'b1111);
    txn("mm",  8'h9A, 1, {8'h00, 8'h00, 8'h00, 8'h55}, 4'b1111);
    txn("rd",  8'h99, 1, {8'h00, 8'h00, 8'h00, 8'hA5}, 4'b1111);
    txn("rd2", 8'h99, 2, {8'h00, 8'h00, 8'hC3, 8'h3C}, 4'b1111);

    // Backpressure NACK, then repeated STARTs part-way through a byte.
    bus_start;
    wr_byte(8'h98, a);
    chk("bp_aack", 32'(a), 32'(ACK));
    rv0 = rxv_cyc;
    usr_if.rx_ready = 1'b0;
    wr_byte(8'h11, a);
    chk("bp_nack", 32'(a), 32'(NACK));
    chk("bp_hold", 32'(usr_if.rx_data), 32'(exp_rx));
    chk("bp_no_rxv", rxv_cyc - rv0, 0);
    usr_if.rx_ready = 1'b1;
    d = 8'h22;
    for (int i = 7; i >= 4; i--) send_bit(d[i], s);
    bus_start;
    chk("rs_busy_clr", 32'(usr_if.busy), 32'(0));
    wr_byte(8'h98, a);
    chk("rs1_aack", 32'(a), 32'(ACK));
    chk("rs1_busy", 32'(usr_if.busy), 32'(1));
    for (int i = 7; i >= 4; i--) send_bit(d[i], s);
    bus_start;
    wr_byte(8'h98, a);
    chk("rs2_aack", 32'(a), 32'(ACK));
    wr_byte(8'h66, a);
    chk("rs2_dack", 32'(a), 32'(ACK));
    exp_rx = 8'h66;
    bus_stop;
    chk("rs_rx", 32'(usr_if.rx_data), 32'(exp_rx));
    chk("rs_idle", 32'(usr_if.busy), 32'(0));

    // Reset while the target holds the address ACK low.
    bus_start;
    d = 8'h98;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    m_low = 1'b0;
    wait_q(Q);
    chk("ra_drv", 32'(sda), 32'(0));
    res = 1'b0;
    #1;
    chk("ra_sda_z", 32'(sda), 32'(1));
    chk("ra_rx_data", 32'(usr_if.rx_data), 32'(0));
    chk("ra_rx_valid", 32'(usr_if.rx_valid), 32'(0));
    chk("ra_tx_ack", 32'(usr_if.tx_ack), 32'(0));
    chk("ra_busy", 32'(usr_if.busy), 32'(0));
    exp_rx = 8'h00;
    wait_q(2);
    scl = 1'b1;
    wait_q(Q);
    res = 1'b1;
    wait_q(Q);
    txn("post", 8'h98, 1, {8'h00, 8'h00, 8'h00, 8'h5A}, 4'b1111);

    for (int t = 0; t < 10; t++) begin
      a7  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SADDR;
      dat = $urandom;
      rdy = 4'($urandom | $urandom);
      txn($sformatf("rnd%0d", t), {a7, 1'($urandom_range(0, 1))}, $urandom_range(1, 3), dat, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
